rk_sum_seq: RTL and testbench
=============================

RK_SUM_SEQ -- requirements
Module: rk_sum_seq

Interface
REQ-001 Parameter: n, default 32, datapath width in bits of all k inputs and result (two's complement signed).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to compute one weighted sum; sampled only in IDLE.
REQ-005 k1  input  n  signed slope term 1.
REQ-006 k2  input  n  signed slope term 2.
REQ-007 k3  input  n  signed slope term 3.
REQ-008 k4  input  n  signed slope term 4.
REQ-009 result  output  n  signed registered sum S = k1 + 2*k2 + 2*k3 + k4.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 busy  output  1  high while a computation is in progress (states S1..S4).
REQ-012 ovf  output  1  signed overflow occurred in any step of the last computation.

Function
REQ-013 Block SHALL use exactly one n-bit signed adder instance (a + b + cin, cin tied 0) time-shared across all steps; no other adders on the datapath.
REQ-014 FSM states SHALL be IDLE, S1, S2, S3, S4, DONE; one-hot or binary encoding is free.
REQ-015 IDLE with start=1 at edge E0: k1..k4 captured into internal registers, ovf cleared, next state S1; start=0 stays IDLE.
REQ-016 S1 SHALL compute acc = k2 + k3; S2 acc = acc + acc; S3 acc = acc + k1; S4 acc = acc + k4; each step takes exactly one cycle.
REQ-017 After the S4 edge (E4), result SHALL hold the final acc, done = 1, and state = DONE; after E5, done = 0 and state = IDLE.
REQ-018 Latency: done high during the cycle following E4, i.e. 4 clock edges after the start-sampling edge E0.
REQ-019 busy SHALL be 1 exactly in S1..S4, 0 in IDLE and DONE.
REQ-020 start asserted in S1..S4 or DONE SHALL be ignored (no queuing); back-to-back computations therefore start no sooner than 6 cycles apart.
REQ-021 k1..k4 changes after E0 SHALL not affect the running computation (captured copies are used).
REQ-022 Per step, signed overflow = both adder operands same sign and sum sign differs; ovf SHALL set (sticky) on any step's overflow until the next accepted start.
REQ-023 Without saturation, results SHALL wrap modulo 2^n; the adder carry-out is not used for overflow.
REQ-024 result SHALL hold its value from DONE until the next DONE (unchanged through IDLE and S1..S4).

Reset
REQ-025 rst=1 at any edge SHALL force state IDLE, result = 0, done = 0, busy = 0, ovf = 0, internal acc and k copies = 0.
REQ-026 rst during S1..S4 or DONE SHALL abort the computation with no done pulse; rst has priority over start.
REQ-027 First start is accepted on the first edge with rst=0 and start=1.

Configuration
REQ-028 Macro RK_SUM_SAT_EN: when defined, each step overflowing positive (operands non-negative) SHALL clamp acc to 2^(n-1)-1 and each overflowing negative to -2^(n-1); ovf still sets.
REQ-029 When RK_SUM_SAT_EN is undefined, no clamp logic SHALL be present and results wrap per REQ-023.

Verification
REQ-030 n=32, k1=1,k2=2,k3=3,k4=4, start pulse -> done 4 edges later, result=15, ovf=0, busy high for 4 cycles.
REQ-031 n=32, k1=-10,k2=5,k3=-7,k4=3 -> result=-11, ovf=0.
REQ-032 n=8, k1=0,k2=64,k3=0,k4=0 -> S2 overflows; without RK_SUM_SAT_EN result=-128 (0x80), ovf=1; with it result=127, ovf=1.
REQ-033 n=32, start held high continuously with k1..k4=1 -> done every 6 cycles, result=6 each time, starts during busy ignored.
REQ-034 rst asserted in S3 -> next cycle state IDLE, busy=0, result=0, ovf=0, no done pulse; next start computes correctly.
REQ-035 k inputs changed to random values at E1 after start with k=1,1,1,1 -> result=6 (captured values used).

Source files
------------

// File: rtl/rk_sum_seq.sv
// Weighted slope sum S = k1 + 2*k2 + 2*k3 + k4 computed over four cycles on one time-shared adder.
// Latency: done pulses 4 edges after the start-sampling edge; result holds until the next done.
// Backpressure: start is only taken in IDLE, so it is dropped (not queued) while busy or in DONE.
// Optional macro RK_SUM_SAT_EN: clamp each overflowing step to the signed min/max instead of wrapping.
module rk_sum_seq #(
  parameter int n = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [n-1:0] k1,
  input  logic signed [n-1:0] k2,
  input  logic signed [n-1:0] k3,
  input  logic signed [n-1:0] k4,
  output logic signed [n-1:0] result,
  output logic                done,
  output logic                busy,
  output logic                ovf
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, DONE} state_t;

  state_t              state;
  logic signed [n-1:0] acc;
  logic signed [n-1:0] k1_q, k2_q, k3_q, k4_q;
  logic signed [n-1:0] add_a, add_b, sum, step_val;
  logic                cin;
  logic                step_ovf;

  // Operand steering for the single shared adder: S1 k2+k3, S2 acc+acc, S3 acc+k1, S4 acc+k4.
  always_comb begin
    add_a = acc;
    add_b = acc;
    case (state)
      S1: begin
        add_a = k2_q;
        add_b = k3_q;
      end
      S3: add_b = k1_q;
      S4: add_b = k4_q;
      default: begin
        add_a = acc;
        add_b = acc;
      end
    endcase
  end

  assign cin      = 1'b0;
  assign sum      = add_a + add_b + {{(n-1){1'b0}}, cin};
  assign step_ovf = (add_a[n-1] == add_b[n-1]) && (sum[n-1] != add_a[n-1]);

`ifdef RK_SUM_SAT_EN
  localparam logic signed [n-1:0] SMAX = {1'b0, {(n-1){1'b1}}};
  localparam logic signed [n-1:0] SMIN = {1'b1, {(n-1){1'b0}}};
  assign step_val = step_ovf ? (add_a[n-1] ? SMIN : SMAX) : sum;
`else
  assign step_val = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      k1_q   <= '0;
      k2_q   <= '0;
      k3_q   <= '0;
      k4_q   <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            k1_q  <= k1;
            k2_q  <= k2;
            k3_q  <= k3;
            k4_q  <= k4;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= S1;
          end
        end
        S1: begin
          acc   <= step_val;
          ovf   <= ovf | step_ovf;
          state <= S2;
        end
        S2: begin
          acc   <= step_val;
          ovf   <= ovf | step_ovf;
          state <= S3;
        end
        S3: begin
          acc   <= step_val;
          ovf   <= ovf | step_ovf;
          state <= S4;
        end
        S4: begin
          acc    <= step_val;
          result <= step_val;
          ovf    <= ovf | step_ovf;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rk_sum_seq.sv
// Directed bench for rk_sum_seq: a 32-bit instance for function/timing and an 8-bit instance for overflow.
module tb_rk_sum_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               start = 1'b0;
  logic signed [31:0] k1 = '0, k2 = '0, k3 = '0, k4 = '0;
  logic signed [31:0] result;
  logic               done, busy, ovf;

  logic              start8 = 1'b0;
  logic signed [7:0] j1 = '0, j2 = '0, j3 = '0, j4 = '0;
  logic signed [7:0] result8;
  logic              done8, busy8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rk_sum_seq #(.n(32)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .k1(k1), .k2(k2), .k3(k3), .k4(k4),
    .result(result), .done(done), .busy(busy), .ovf(ovf)
  );

  rk_sum_seq #(.n(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .k1(j1), .k2(j2), .k3(j3), .k4(j4),
    .result(result8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  // Pulse start, wait (bounded) for done, then step one more edge so the DUT is back in IDLE.
  task automatic run32(input logic signed [31:0] a, b, c, d,
                       output logic signed [31:0] res, output logic ov,
                       output int lat, output int bcnt, output logic done_after);
    logic seen;
    k1 = a; k2 = b; k3 = c; k4 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0; lat = 0; bcnt = 0; res = 'x; ov = 1'bx; done_after = 1'bx;
    if (busy) bcnt++;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1; lat = i; res = result; ov = ovf;
      end else if (busy) bcnt++;
    end
    if (seen) begin
      @(posedge clk); #1;
      done_after = done;
    end
  endtask

  task automatic run8(input logic signed [7:0] a, b, c, d,
                      output logic signed [7:0] res, output logic ov, output int lat);
    logic seen;
    j1 = a; j2 = b; j3 = c; j4 = d;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    seen = 1'b0; lat = 0; res = 'x; ov = 1'bx;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        seen = 1'b1; lat = i; res = result8; ov = ovf8;
      end
    end
    if (seen) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic seen;
    rst = 1'b1; start = 1'b1;
    k1 = 1; k2 = 2; k3 = 3; k4 = 4;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'sd0 || done !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset32: result=%0d done=%b busy=%b ovf=%b, required 0 0 0 0", result, done, busy, ovf);
    end
    checks++;
    if (result8 !== 8'sd0 || done8 !== 1'b0 || busy8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: result=%0d done=%b busy=%b ovf=%b, required 0 0 0 0", result8, done8, busy8, ovf8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_accept: busy=%b, required 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || result !== 32'sd15) begin
      errors++;
      $display("FAIL first_result: done_seen=%b result=%0d, required 1 15", seen, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic signed [31:0] res;
    logic ov, da;
    int lat, bcnt;
    run32(1, 2, 3, 4, res, ov, lat, bcnt, da);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d edges, required 4", lat); end
    checks++;
    if (res !== 32'sd15) begin errors++; $display("FAIL basic_result: got %0d, required 15", res); end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b, required 0", ov); end
    checks++;
    if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d, required 4", bcnt); end
    checks++;
    if (da !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b after DONE, required 0 0", da, busy);
    end
  endtask

  task automatic test_negative;
    logic signed [31:0] res;
    logic ov, da;
    int lat, bcnt;
    run32(-10, 5, -7, 3, res, ov, lat, bcnt, da);
    checks++;
    if (res !== -32'sd11) begin errors++; $display("FAIL neg_result: got %0d, required -11", res); end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b, required 0", ov); end
    checks++;
    if (result !== -32'sd11) begin errors++; $display("FAIL neg_result_hold: got %0d in IDLE, required -11", result); end
  endtask

  task automatic test_overflow8;
    logic signed [7:0] res, exp_pos, exp_neg;
    logic ov;
    int lat;
`ifdef RK_SUM_SAT_EN
    exp_pos = 8'sd127;
    exp_neg = -8'sd128;
`else
    exp_pos = -8'sd128;
    exp_neg = 8'sd126;
`endif
    // 64 -> 128 in the doubling step overflows positive; later steps add 0.
    run8(0, 64, 0, 0, res, ov, lat);
    checks++;
    if (res !== exp_pos) begin errors++; $display("FAIL ovf8_pos_result: got %0d, required %0d", res, exp_pos); end
    checks++;
    if (ov !== 1'b1) begin errors++; $display("FAIL ovf8_pos_flag: got %b, required 1", ov); end
    // -65 doubled is -130, overflowing negative.
    run8(0, -65, 0, 0, res, ov, lat);
    checks++;
    if (res !== exp_neg || ov !== 1'b1) begin
      errors++; $display("FAIL ovf8_neg: result=%0d ovf=%b, required %0d 1", res, ov, exp_neg);
    end
    run8(1, 1, 1, 1, res, ov, lat);
    checks++;
    if (res !== 8'sd6 || ov !== 1'b0) begin
      errors++; $display("FAIL ovf8_clear: result=%0d ovf=%b, required 6 0", res, ov);
    end
    // Leave ovf set so the abort test can see it cleared by reset.
    run8(0, 64, 0, 0, res, ov, lat);
    checks++;
    if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf8_sticky_idle: got %b, required 1", ovf8); end
  endtask

  task automatic test_back_to_back;
    int ndone, prev, bad_gap, bad_res;
    k1 = 1; k2 = 1; k3 = 1; k4 = 1;
    start = 1'b1;
    ndone = 0; prev = 0; bad_gap = 0; bad_res = 0;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (result !== 32'sd6) bad_res++;
        if (prev != 0 && (i - prev) != 6) bad_gap++;
        prev = i;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 4) begin errors++; $display("FAIL b2b_count: got %0d done pulses, required 4", ndone); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing: %0d gaps not 6 cycles, required 0", bad_gap); end
    checks++;
    if (bad_res !== 0) begin errors++; $display("FAIL b2b_result: %0d results not 6, required 0", bad_res); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_capture;
    logic seen;
    k1 = 1; k2 = 1; k3 = 1; k4 = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k1 = $urandom; k2 = $urandom; k3 = $urandom; k4 = $urandom;
    @(posedge clk); #1;
    k1 = $urandom; k2 = $urandom; k3 = $urandom; k4 = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || result !== 32'sd6) begin
      errors++; $display("FAIL capture: done_seen=%b result=%0d, required 1 6", seen, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    logic signed [31:0] res;
    logic ov, da;
    int lat, bcnt, ndone;
    k1 = 1; k2 = 2; k3 = 3; k4 = 4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'sd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort32: busy=%b done=%b result=%0d ovf=%b, required 0 0 0 0", busy, done, result, ovf);
    end
    checks++;
    if (result8 !== 8'sd0 || ovf8 !== 1'b0) begin
      errors++; $display("FAIL abort8: result=%0d ovf=%b, required 0 0", result8, ovf8);
    end
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses, required 0", ndone); end
    run32(1, 2, 3, 4, res, ov, lat, bcnt, da);
    checks++;
    if (res !== 32'sd15 || lat !== 4) begin
      errors++; $display("FAIL abort_restart: result=%0d latency=%0d, required 15 4", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow8();
    test_back_to_back();
    test_capture();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
